// File: rtl/rv32_pkg.sv
// rv32_pkg: RV32I opcodes, ALU op codes, immediate formats and the decoded-slot bundle
package rv32_pkg;
  localparam int XLEN = 32;
  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] JAL    = 7'h6F;
  localparam logic [6:0] JALR   = 7'h67;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] AUIPC  = 7'h17;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
    ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
    ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10
  } alu_op_e;
  typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    alu_op_e         alu_op;
    logic            alu_src_imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            jalr;
    logic            lui;
    logic            auipc;
    logic            illegal;
  } dec_t;
  function automatic logic [XLEN-1:0] imm_gen(imm_fmt_e f, logic [31:0] i);
    return f == IMM_I ? {{20{i[31]}}, i[31:20]}
         : f == IMM_S ? {{20{i[31]}}, i[31:25], i[11:7]}
         : f == IMM_B ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}
         : f == IMM_U ? {i[31:12], 12'b0}
         : f == IMM_J ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}
         : '0;
  endfunction
  // alt selects SUB/SRA; it is only meaningful for funct3 0 and 5
  function automatic alu_op_e alu_of(logic [2:0] f3, logic alt);
    return f3 == 3'd0 ? (alt ? ALU_SUB : ALU_ADD)
         : f3 == 3'd1 ? ALU_SLL
         : f3 == 3'd2 ? ALU_SLT
         : f3 == 3'd3 ? ALU_SLTU
         : f3 == 3'd4 ? ALU_XOR
         : f3 == 3'd5 ? (alt ? ALU_SRA : ALU_SRL)
         : f3 == 3'd6 ? ALU_OR
         : ALU_AND;
  endfunction
endpackage

// File: rtl/decode_regfile.sv
// decode_regfile: 32x32 register file, two async reads with write-through bypass, one sync write
module decode_regfile import rv32_pkg::*; (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);
  logic [XLEN-1:0] regs [1:31];
  always_ff @(posedge clk)
    if (!rst)
      for (int k = 1; k < 32; k++) regs[k] <= '0;
    else if (wb_en && wb_rd != 5'd0)
      regs[wb_rd] <= wb_data;
  assign rs1_data = rs1 == 5'd0 ? '0 : (wb_en && wb_rd == rs1) ? wb_data : regs[rs1];
  assign rs2_data = rs2 == 5'd0 ? '0 : (wb_en && wb_rd == rs2) ? wb_data : regs[rs2];
endmodule

// File: rtl/decode.sv
// decode: RV32I decode stage -- register file read, immediate and control generation, one-cycle output register
module decode import rv32_pkg::*; (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] i_instruction,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_flush,
  input  logic            i_wb_en,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_funct3,
  output logic [3:0]      o_alu_op,
  output logic            o_alu_src_imm,
  output logic            o_reg_write,
  output logic            o_mem_read,
  output logic            o_mem_write,
  output logic            o_branch,
  output logic            o_jump,
  output logic            o_jalr,
  output logic            o_lui,
  output logic            o_auipc,
  output logic            o_illegal
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd;
  imm_fmt_e fmt;
  alu_op_e alu;
  logic src_imm, rw, mr, mw, br, jmp, jr, lu, au, ill;
  logic [XLEN-1:0] rs1_data, rs2_data;
  dec_t d, q;
  assign opc = i_instruction[6:0];
  assign f3 = i_instruction[14:12];
  assign f7 = i_instruction[31:25];
  assign rd = i_instruction[11:7];
  decode_regfile u_rf (
    .clk(clk), .rst(rst),
    .rs1(i_instruction[19:15]), .rs2(i_instruction[24:20]),
    .wb_en(i_wb_en), .wb_rd(i_wb_rd), .wb_data(i_wb_data),
    .rs1_data(rs1_data), .rs2_data(rs2_data)
  );
  always_comb begin
    fmt = IMM_R;
    alu = ALU_ADD;
    {src_imm, rw, mr, mw, br, jmp, jr, lu, au, ill} = '0;
    case (opc)
      OP: begin
        rw = 1'b1;
        alu = alu_of(f3, f7[5]);
        ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      OP_IMM: begin
        fmt = IMM_I;
        {rw, src_imm} = 2'b11;
        alu = alu_of(f3, f3 == 3'd5 && f7[5]);
        ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      end
      LOAD: begin
        fmt = IMM_I;
        {rw, mr, src_imm} = 3'b111;
        ill = f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7;
      end
      STORE: begin
        fmt = IMM_S;
        {mw, src_imm} = 2'b11;
        ill = f3 > 3'd2;
      end
      BRANCH: begin
        fmt = IMM_B;
        br = 1'b1;
        alu = ALU_SUB;
        ill = f3 == 3'd2 || f3 == 3'd3;
      end
      JAL: begin
        fmt = IMM_J;
        {jmp, rw} = 2'b11;
      end
      JALR: begin
        fmt = IMM_I;
        {jr, rw, src_imm} = 3'b111;
        ill = f3 != 3'd0;
      end
      LUI: begin
        fmt = IMM_U;
        {lu, rw, src_imm} = 3'b111;
        alu = ALU_PASSB;
      end
      AUIPC: begin
        fmt = IMM_U;
        {au, rw, src_imm} = 3'b111;
      end
      default: ill = 1'b1;
    endcase
  end
  // an illegal slot stays valid so execute can trap, but must have no side effects
  always_comb begin
    d.valid = 1'b1;
    d.pc = i_pc;
    d.rs1_data = rs1_data;
    d.rs2_data = rs2_data;
    d.rs1 = i_instruction[19:15];
    d.rs2 = i_instruction[24:20];
    d.rd = rd;
    d.imm = imm_gen(fmt, i_instruction);
    d.funct3 = f3;
    d.alu_op = ill ? ALU_ADD : alu;
    d.alu_src_imm = src_imm && !ill;
    d.reg_write = rw && !ill && rd != 5'd0;
    d.mem_read = mr && !ill;
    d.mem_write = mw && !ill;
    d.branch = br && !ill;
    d.jump = jmp && !ill;
    d.jalr = jr && !ill;
    d.lui = lu && !ill;
    d.auipc = au && !ill;
    d.illegal = ill;
  end
  always_ff @(posedge clk)
    q <= (!rst || i_flush || i_instruction == '0) ? '0 : d;
  assign o_valid = q.valid;
  assign o_pc = q.pc;
  assign o_rs1_data = q.rs1_data;
  assign o_rs2_data = q.rs2_data;
  assign o_rs1 = q.rs1;
  assign o_rs2 = q.rs2;
  assign o_rd = q.rd;
  assign o_imm = q.imm;
  assign o_funct3 = q.funct3;
  assign o_alu_op = q.alu_op;
  assign o_alu_src_imm = q.alu_src_imm;
  assign o_reg_write = q.reg_write;
  assign o_mem_read = q.mem_read;
  assign o_mem_write = q.mem_write;
  assign o_branch = q.branch;
  assign o_jump = q.jump;
  assign o_jalr = q.jalr;
  assign o_lui = q.lui;
  assign o_auipc = q.auipc;
  assign o_illegal = q.illegal;
endmodule

// File: tb/tb_decode.sv
// tb_decode: directed and random stimulus for decode, checked against a behavioural decode/regfile model
module tb_decode;
  import rv32_pkg::*;
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] i_instruction = '0, i_pc = '0, i_wb_data = '0;
  logic i_flush = 1'b0, i_wb_en = 1'b0;
  logic [4:0] i_wb_rd = '0;
  logic o_valid, o_alu_src_imm, o_reg_write, o_mem_read, o_mem_write, o_branch;
  logic o_jump, o_jalr, o_lui, o_auipc, o_illegal;
  logic [31:0] o_pc, o_rs1_data, o_rs2_data, o_imm;
  logic [4:0] o_rs1, o_rs2, o_rd;
  logic [2:0] o_funct3;
  logic [3:0] o_alu_op;
  int vectors = 0, errors = 0;
  logic [31:0] ref_rf [32];
  logic [31:0] pcv = 32'h1000;
  dec_t got, exp;

  decode dut (
    .clk(clk), .rst(rst), .i_instruction(i_instruction), .i_pc(i_pc), .i_flush(i_flush),
    .i_wb_en(i_wb_en), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .o_valid(o_valid), .o_pc(o_pc), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_imm(o_imm), .o_funct3(o_funct3),
    .o_alu_op(o_alu_op), .o_alu_src_imm(o_alu_src_imm), .o_reg_write(o_reg_write),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_branch(o_branch), .o_jump(o_jump),
    .o_jalr(o_jalr), .o_lui(o_lui), .o_auipc(o_auipc), .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  always_comb begin
    got.valid = o_valid;
    got.pc = o_pc;
    got.rs1_data = o_rs1_data;
    got.rs2_data = o_rs2_data;
    got.rs1 = o_rs1;
    got.rs2 = o_rs2;
    got.rd = o_rd;
    got.imm = o_imm;
    got.funct3 = o_funct3;
    got.alu_op = alu_op_e'(o_alu_op);
    got.alu_src_imm = o_alu_src_imm;
    got.reg_write = o_reg_write;
    got.mem_read = o_mem_read;
    got.mem_write = o_mem_write;
    got.branch = o_branch;
    got.jump = o_jump;
    got.jalr = o_jalr;
    got.lui = o_lui;
    got.auipc = o_auipc;
    got.illegal = o_illegal;
  end

  function automatic logic [31:0] rd_ref(input logic [4:0] k, input logic we, input logic [4:0] wr, input logic [31:0] wd);
    return k == 0 ? 32'd0 : (we && wr == k) ? wd : ref_rf[k];
  endfunction

  // reference decoder written from the ISA encoding rules
  function automatic dec_t model(input logic [31:0] i, input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b);
    dec_t e;
    int alu_tab[8];
    logic [2:0] f3;
    logic [6:0] f7;
    logic ok;
    logic signed [12:0] bo;
    logic signed [20:0] jo;
    logic [31:0] iimm;
    alu_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
    f3 = i[14:12];
    f7 = i[31:25];
    ok = 1'b1;
    bo = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    jo = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    iimm = 32'($signed(i) >>> 20);
    e = '0;
    if (i == 0) return e;
    e.valid = 1'b1;
    e.pc = pc;
    e.rs1_data = a;
    e.rs2_data = b;
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.rd = i[11:7];
    e.funct3 = f3;
    case (i[6:0])
      7'h33: begin
        ok = f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        e.alu_op = alu_op_e'(4'(f7 == 7'h20 && f3 == 0 ? 1 : f7 == 7'h20 && f3 == 5 ? 7 : alu_tab[f3]));
        e.reg_write = 1'b1;
      end
      7'h13: begin
        ok = !(f3 == 1 && f7 != 0) && !(f3 == 5 && f7 != 0 && f7 != 7'h20);
        e.alu_op = alu_op_e'(4'(f7 == 7'h20 && f3 == 5 ? 7 : alu_tab[f3]));
        e.imm = iimm;
        e.alu_src_imm = 1'b1;
        e.reg_write = 1'b1;
      end
      7'h03: begin
        ok = f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5;
        e.imm = iimm;
        e.alu_src_imm = 1'b1;
        e.reg_write = 1'b1;
        e.mem_read = 1'b1;
      end
      7'h23: begin
        ok = f3 <= 2;
        e.imm = (iimm & ~32'h1F) | 32'(i[11:7]);
        e.alu_src_imm = 1'b1;
        e.mem_write = 1'b1;
      end
      7'h63: begin
        ok = f3 != 2 && f3 != 3;
        e.imm = 32'(bo);
        e.alu_op = ALU_SUB;
        e.branch = 1'b1;
      end
      7'h6F: begin
        e.imm = 32'(jo);
        e.jump = 1'b1;
        e.reg_write = 1'b1;
      end
      7'h67: begin
        ok = f3 == 0;
        e.imm = iimm;
        e.alu_src_imm = 1'b1;
        e.jalr = 1'b1;
        e.reg_write = 1'b1;
      end
      7'h37: begin
        e.imm = i & 32'hFFFFF000;
        e.alu_op = ALU_PASSB;
        e.alu_src_imm = 1'b1;
        e.lui = 1'b1;
        e.reg_write = 1'b1;
      end
      7'h17: begin
        e.imm = i & 32'hFFFFF000;
        e.alu_src_imm = 1'b1;
        e.auipc = 1'b1;
        e.reg_write = 1'b1;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e.alu_op = ALU_ADD;
      {e.alu_src_imm, e.reg_write, e.mem_read, e.mem_write, e.branch} = '0;
      {e.jump, e.jalr, e.lui, e.auipc} = '0;
      e.illegal = 1'b1;
    end
    if (e.rd == 0) e.reg_write = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    logic [31:0] w;
    int s;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
    w = $urandom;
    s = $urandom_range(0, 12);
    if (s == 12) return 32'd0;
    if (s < 10) w[6:0] = ops[s];
    if ((w[6:0] == 7'h33 || w[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
      w[31:25] = $urandom_range(0, 1) == 1 ? 7'h20 : 7'h00;
    return w;
  endfunction

  task automatic step(input logic [31:0] ins, input logic fl, input logic we, input logic [4:0] wr,
                      input logic [31:0] wd, input logic r);
    @(negedge clk);
    i_instruction = ins;
    i_pc = pcv;
    i_flush = fl;
    i_wb_en = we;
    i_wb_rd = wr;
    i_wb_data = wd;
    rst = r;
    exp = (!r || fl) ? '0 : model(ins, pcv, rd_ref(ins[19:15], we, wr, wd), rd_ref(ins[24:20], we, wr, wd));
    pcv = pcv + 4;
    @(posedge clk);
    if (!r) for (int k = 0; k < 32; k++) ref_rf[k] = '0;
    else if (we && wr != 0) ref_rf[wr] = wd;
    #1;
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL bundle ins=%h observed=%h expected=%h", ins, got, exp);
    end
  endtask

  task automatic go(input logic [31:0] ins);
    step(ins, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  initial begin
    logic [31:0] w;
    for (int n = 0; n < 3; n++) begin
      step($urandom, 1'($urandom), 1'b1, 5'($urandom), $urandom, 1'b0);
      chk("rst_valid", 32'(o_valid), 32'd0);
    end
    go(32'd0);
    chk("reset_word_bubble", {31'd0, o_valid}, 32'd0);
    for (int k = 1; k < 32; k++) begin
      go({7'd0, 5'(k), 5'(k), 3'd0, 5'd0, 7'h33});
      chk("rf_clear", o_rs1_data | o_rs2_data, 32'd0);
    end
    go(32'hFFF00293);
    chk("addi_imm", o_imm, 32'hFFFFFFFF);
    chk("addi_alu", 32'(o_alu_op), 32'd0);
    chk("addi_src", {o_alu_src_imm, o_reg_write, o_valid}, 32'h7);
    chk("addi_rd", 32'(o_rd), 32'd5);
    step({7'd0, 5'd3, 5'd3, 3'd0, 5'd1, 7'h33}, 1'b0, 1'b1, 5'd3, 32'h1234, 1'b1);
    chk("bypass_rs1", o_rs1_data, 32'h1234);
    chk("bypass_rs2", o_rs2_data, 32'h1234);
    step({7'd0, 5'd0, 5'd0, 3'd0, 5'd1, 7'h33}, 1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b1);
    chk("x0_bypass", o_rs1_data, 32'd0);
    go({7'd0, 5'd0, 5'd0, 3'd0, 5'd1, 7'h33});
    chk("x0_read", o_rs1_data, 32'd0);
    go({1'b1, 6'b111111, 5'd2, 5'd1, 3'b000, 4'b1100, 1'b1, 7'h63});
    chk("beq_imm", o_imm, 32'hFFFFFFF8);
    chk("beq_ctl", {o_alu_op, o_branch, o_reg_write}, 32'h6);
    go({1'b0, 10'd0, 1'b1, 8'd0, 5'd1, 7'h6F});
    chk("jal_imm", o_imm, 32'h800);
    chk("jal_jump", {o_jump, o_reg_write}, 32'h3);
    go({7'h7F, 5'd2, 5'd1, 3'b010, 5'b11100, 7'h23});
    chk("sw_imm", o_imm, 32'hFFFFFFFC);
    chk("sw_mw", {o_mem_write, o_reg_write}, 32'h2);
    step({12'd0, 5'd1, 3'b010, 5'd4, 7'h03}, 1'b1, 1'b1, 5'd7, 32'hCAFEF00D, 1'b1);
    chk("flush_valid", {o_valid, o_mem_read, o_reg_write, o_illegal}, 32'd0);
    go({7'd0, 5'd0, 5'd7, 3'd0, 5'd1, 7'h33});
    chk("flush_wb", o_rs1_data, 32'hCAFEF00D);
    go({25'h1234, 7'h7F});
    chk("illegal_op", {o_illegal, o_valid, o_reg_write}, 32'h6);
    go({7'h20, 5'd2, 5'd1, 3'b001, 5'd3, 7'h33});
    chk("illegal_f7", {o_illegal, o_reg_write}, 32'h2);
    for (int n = 0; n < 400; n++) begin
      w = rand_instr();
      step(w, $urandom_range(0, 7) == 0, 1'($urandom),
           $urandom_range(0, 2) == 0 ? w[19:15] : 5'($urandom), $urandom, 1'b1);
    end
    step(rand_instr(), 1'b1, 1'b1, 5'd9, 32'h5A5A5A5A, 1'b0);
    chk("rst_over_wb", 32'(o_valid), 32'd0);
    go({7'd0, 5'd9, 5'd9, 3'd0, 5'd0, 7'h33});
    chk("rst_clears_x9", o_rs1_data, 32'd0);
    for (int n = 0; n < 100; n++) begin
      w = rand_instr();
      step(w, $urandom_range(0, 7) == 0, 1'($urandom), 5'($urandom), $urandom, 1'b1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
